// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the instruction sequencer of the 6-bit-opcode core.
// Contents:
//   seqState_e - sequencer state encoding (IDLE, FETCH, EXEC, MEM, HALTED)
//   LOAD..HAS_FUNCB - major opcode values carried in opcode[5:3]
//   LSL..HALT - A-type function codes carried in opcode[2:0] under HAS_FUNCA
//   BNO, BOF - B-type branch selector carried in opcode[2] under HAS_FUNCB
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        HALTED
    } seqState_e;

    localparam logic [2:0] LOAD      = 3'b000;
    localparam logic [2:0] STORE     = 3'b001;
    localparam logic [2:0] ADD       = 3'b010;
    localparam logic [2:0] MATCH     = 3'b011;
    localparam logic [2:0] LT        = 3'b100;
    localparam logic [2:0] DIST      = 3'b101;
    localparam logic [2:0] HAS_FUNCA = 3'b110;
    localparam logic [2:0] HAS_FUNCB = 3'b111;

    localparam logic [2:0] LSL  = 3'b000;
    localparam logic [2:0] LSR  = 3'b001;
    localparam logic [2:0] INCR = 3'b010;
    localparam logic [2:0] AND1 = 3'b011;
    localparam logic [2:0] EQZ  = 3'b100;
    localparam logic [2:0] ZERO = 3'b101;
    localparam logic [2:0] TBD  = 3'b110;
    localparam logic [2:0] HALT = 3'b111;

    localparam logic BNO = 1'b0;
    localparam logic BOF = 1'b1;

endpackage

// File: rtl/op_classify.sv
// op_classify
// Purely combinational decode of a 6-bit opcode into the handful of
// attributes the sequencer needs to pick its next state.
// Ports:
//   opcode_i        - instruction bits [5:0]
//   is_mem_o        - LOAD or STORE, needs a data-memory phase
//   is_store_o      - STORE (memory write)
//   writes_reg_o    - instruction eventually writes the register file
//   is_branch_o     - BNO or BOF
//   branch_on_ovf_o - branch is taken when overflow equals this bit
//   is_halt_o       - HALT
module op_classify (
    input  logic [5:0] opcode_i,
    output logic       is_mem_o,
    output logic       is_store_o,
    output logic       writes_reg_o,
    output logic       is_branch_o,
    output logic       branch_on_ovf_o,
    output logic       is_halt_o
);
    import seq_pkg::*;

    // Major opcode selects the class; A-type ops refine it with the func field
    // (TBD is a silent no-op, HALT stops the run), B-type ops pick the branch
    // polarity from bit 2.
    always_comb begin
        is_mem_o        = 1'b0;
        is_store_o      = 1'b0;
        writes_reg_o    = 1'b0;
        is_branch_o     = 1'b0;
        branch_on_ovf_o = 1'b0;
        is_halt_o       = 1'b0;
        case (opcode_i[5:3])
            LOAD: begin
                is_mem_o     = 1'b1;
                writes_reg_o = 1'b1;
            end
            STORE: begin
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
            end
            ADD, MATCH, LT, DIST: begin
                writes_reg_o = 1'b1;
            end
            HAS_FUNCA: begin
                case (opcode_i[2:0])
                    LSL, LSR, INCR, AND1, EQZ, ZERO: writes_reg_o = 1'b1;
                    TBD:                             writes_reg_o = 1'b0;
                    HALT:                            is_halt_o    = 1'b1;
                    default:                         writes_reg_o = 1'b0;
                endcase
            end
            HAS_FUNCB: begin
                is_branch_o = 1'b1;
                case (opcode_i[2])
                    BNO:     branch_on_ovf_o = 1'b0;
                    BOF:     branch_on_ovf_o = 1'b1;
                    default: branch_on_ovf_o = 1'b0;
                endcase
            end
            default: begin
                is_mem_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer
// Multi-cycle sequencer for the 6-bit-opcode core. Owns the program counter,
// walks each instruction through FETCH and EXEC (plus a handshaked MEM phase
// for LOAD/STORE), resolves BNO/BOF against the ALU overflow flag, stops on
// HALT and counts busy cycles (saturating).
// Parameters:
//   PC_W        - program counter width
//   CNT_W       - cycle counter width
//   MEM_TIMEOUT - MEM cycles without mem_ack before the watchdog fires
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-high reset
//   start         - begin a run at pc 0 (only from IDLE or HALTED)
//   opcode        - instruction from ROM, valid in EXEC
//   overflow      - ALU overflow flag, sampled in EXEC
//   branch_target - branch destination, sampled in EXEC
//   mem_ack       - data memory completes the pending request
//   pc            - current instruction address
//   imem_en       - instruction ROM read enable
//   mem_req       - data memory request, mem_we gives direction (1 = store)
//   reg_we        - one-cycle register file write strobe
//   busy, done    - run in progress / HALT retired
//   err           - watchdog fired
//   cycle_count   - busy cycles since start, saturating
// Configuration macro:
//   SEQ_WATCHDOG_EN - when defined, a MEM phase lasting MEM_TIMEOUT cycles
//                     without mem_ack halts the run with err set; otherwise
//                     MEM waits forever and err is tied low.
module instr_sequencer #(
    parameter int PC_W        = 10,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             overflow,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             mem_ack,
    output logic [PC_W-1:0]  pc,
    output logic             imem_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_count
);
    import seq_pkg::*;

    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seqState_e        state_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pcInc;
    logic [CNT_W-1:0] cycleCnt_q;
    logic [CNT_W-1:0] cycleCnt_d;
    logic             imemEn_q;
    logic             memReq_q;
    logic             memWe_q;
    logic             regWe_q;
    logic             busy_q;
    logic             done_q;

    logic isMem;
    logic isStore;
    logic writesReg;
    logic isBranch;
    logic branchOnOvf;
    logic isHalt;

`ifdef SEQ_WATCHDOG_EN
    localparam int             WD_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic            err_q;
    logic [WD_W-1:0] wdCnt_q;
`else
    // MEM_TIMEOUT only matters with the watchdog; reference it so the
    // parameter is still consumed in the default build.
    logic unusedTimeout;
    assign unusedTimeout = |MEM_TIMEOUT;
`endif

    op_classify uClassify (
        .opcode_i       (opcode),
        .is_mem_o       (isMem),
        .is_store_o     (isStore),
        .writes_reg_o   (writesReg),
        .is_branch_o    (isBranch),
        .branch_on_ovf_o(branchOnOvf),
        .is_halt_o      (isHalt)
    );

    // Sequential pc step wraps naturally at 2^PC_W; the cycle counter sticks
    // at all-ones instead of wrapping.
    always_comb begin
        pcInc      = pc_q + PC_ONE;
        cycleCnt_d = cycleCnt_q;
        if (cycleCnt_q != '1) begin
            cycleCnt_d = cycleCnt_q + CNT_ONE;
        end
    end

    // Main FSM. Every output is a register updated on the same edge as the
    // state, so strobes such as reg_we land in the cycle after the deciding
    // state and line up with the new pc. Counting keys off busy_q, which
    // means the edge that leaves the last busy cycle is still counted while
    // HALTED freezes the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            cycleCnt_q <= '0;
            imemEn_q   <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            regWe_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            err_q      <= 1'b0;
            wdCnt_q    <= '0;
`endif
        end else begin
            imemEn_q <= 1'b0;
            regWe_q  <= 1'b0;
            if (busy_q) begin
                cycleCnt_q <= cycleCnt_d;
            end
            case (state_q)
                IDLE, HALTED: begin
                    if (start) begin
                        state_q    <= FETCH;
                        pc_q       <= '0;
                        cycleCnt_q <= '0;
                        imemEn_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (isMem) begin
                        state_q  <= MEM;
                        memReq_q <= 1'b1;
                        memWe_q  <= isStore;
`ifdef SEQ_WATCHDOG_EN
                        wdCnt_q  <= '0;
`endif
                    end else if (isHalt) begin
                        state_q <= HALTED;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= FETCH;
                        imemEn_q <= 1'b1;
                        regWe_q  <= writesReg & ~isBranch;
                        if (isBranch && (overflow == branchOnOvf)) begin
                            pc_q <= branch_target;
                        end else begin
                            pc_q <= pcInc;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state_q  <= FETCH;
                        memReq_q <= 1'b0;
                        regWe_q  <= ~memWe_q;
                        imemEn_q <= 1'b1;
                        pc_q     <= pcInc;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wdCnt_q == WD_LAST) begin
                        state_q  <= HALTED;
                        memReq_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        wdCnt_q <= wdCnt_q + WD_ONE;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign imem_en     = imemEn_q;
    assign mem_req     = memReq_q;
    assign mem_we      = memWe_q;
    assign reg_we      = regWe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cycleCnt_q;
`ifdef SEQ_WATCHDOG_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule
